// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - load/store unit with byte-lane strobes and optional split of boundary-crossing accesses
module lsu_split #(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            req_valid,
    input  logic            req_ren,
    input  logic            req_wen,
    input  logic [1:0]      req_width,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_done,
    output logic [XLEN-1:0] resp_rdata,
    output logic            load_misalign,
    output logic            store_misalign,
    output logic            dmem_ren,
    output logic            dmem_wen,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN/8-1:0] dmem_strb,
    input  logic [XLEN-1:0] dmem_load,
    input  logic            dhit
);
    localparam int NB  = XLEN / 8;
    localparam int NB2 = 2 * NB;
    localparam int LNB = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      r_state;
    logic            r_load;
    logic            r_store;
    logic [1:0]      r_width;
    logic            r_uns;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_beat0;
    logic [XLEN-1:0] r_rdata;
    logic            r_lmis;
    logic            r_smis;

    // Request-side checks use the live inputs since they decide the IDLE transition
    logic [2:0]        w_req_lowmask;
    logic              w_req_illegal;
    logic              w_req_mis;
    logic              w_req_exc;
    logic              w_req_go;

    logic [LNB-1:0]    w_off;
    logic [3:0]        w_off_ext;
    logic [3:0]        w_size;
    logic              w_cross;
    logic [7:0]        w_size_mask;
    logic [NB2-1:0]    w_strb_wide;
    logic [2*XLEN-1:0] w_wdata_wide;
    logic [XLEN-1:0]   w_base;
    logic              w_acc;
    logic              w_hi;
    logic [2*XLEN-1:0] w_asm_in;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_keep;
    logic [XLEN-1:0]   w_top;
    logic              w_neg;
    logic [XLEN-1:0]   w_ext;

    assign w_req_lowmask = 3'b111 >> (2'd3 - req_width);
    assign w_req_illegal = (XLEN == 32) && (req_width == 2'b11);
    assign w_req_mis     = w_req_illegal || ((req_addr[2:0] & w_req_lowmask) != 3'd0);
    assign w_req_exc     = w_req_illegal || (w_req_mis && !SPLIT_MISALIGNED);
    assign w_req_go      = req_valid && (req_ren || req_wen);

    assign w_off       = r_addr[LNB-1:0];
    assign w_off_ext   = {{(4-LNB){1'b0}}, w_off};
    assign w_size      = 4'd1 << r_width;
    assign w_cross     = (w_off_ext + w_size) > 4'(NB);
    assign w_size_mask = 8'((9'd1 << w_size) - 9'd1);

    // Upper halves of the double-width shifts are exactly the second-beat lanes
    assign w_strb_wide  = NB2'(w_size_mask) << w_off;
    assign w_wdata_wide = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_base       = {r_addr[XLEN-1:LNB], {LNB{1'b0}}};

    assign w_acc = (r_state == S_ACC0) || (r_state == S_ACC1);
    assign w_hi  = (r_state == S_ACC1);

    assign dmem_ren   = w_acc && r_load;
    assign dmem_wen   = w_acc && r_store;
    assign dmem_addr  = !w_acc ? '0 : (w_hi ? w_base + XLEN'(NB) : w_base);
    assign dmem_strb  = !w_acc ? '0 : (w_hi ? w_strb_wide[NB2-1:NB] : w_strb_wide[NB-1:0]);
    assign dmem_wdata = !w_acc ? '0 : (w_hi ? w_wdata_wide[2*XLEN-1:XLEN] : w_wdata_wide[XLEN-1:0]);

    assign w_asm_in = w_hi ? {dmem_load, r_beat0} : {{XLEN{1'b0}}, dmem_load};
    assign w_raw    = XLEN'(w_asm_in >> {w_off, 3'b000});
    assign w_keep   = (XLEN'(1) << {w_size, 3'b000}) - XLEN'(1);
    assign w_top    = w_keep ^ (w_keep >> 1);
    assign w_neg    = !r_uns && (|(w_raw & w_top));
    assign w_ext    = (w_raw & w_keep) | (w_neg ? ~w_keep : '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_width <= 2'd0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_beat0 <= '0;
            r_rdata <= '0;
            r_lmis  <= 1'b0;
            r_smis  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_go) begin
                        r_load  <= req_ren;
                        r_store <= !req_ren;
                        r_width <= req_width;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_lmis  <= req_ren && w_req_exc;
                        r_smis  <= !req_ren && w_req_exc;
                        if (w_req_exc) begin
                            r_rdata <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ACC0;
                        end
                    end
                end
                S_ACC0: begin
                    if (dhit) begin
                        r_beat0 <= dmem_load;
                        if (w_cross) begin
                            r_state <= S_ACC1;
                        end else begin
                            r_rdata <= r_load ? w_ext : '0;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ACC1: begin
                    if (dhit) begin
                        r_rdata <= r_load ? w_ext : '0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_done      = (r_state == S_DONE);
    assign resp_rdata     = r_rdata;
    assign load_misalign  = resp_done && r_lmis;
    assign store_misalign = resp_done && r_smis;
endmodule
